// File: rtl/rv32i_types.sv
// Shared types for the fetch/align path.
// align_slot_t carries one decoded output slot, rvc_is_compressed() classifies a halfword.
// Pure declarations: no ports, no latency, no backpressure.
package rv32i_types;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [63:0] order;
        logic        is_compressed;
        logic        valid;
    } align_slot_t;

    // 48-bit and longer encodings are not distinguished; anything ending in 2'b11 is RV32.
    function automatic logic rvc_is_compressed(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/hw_ring_buffer.sv
// Halfword ring buffer: writes the tail part of a block, exposes 4 halfwords at head.
// Latency: a write at edge t is visible on o_peek/o_count from cycle t+1.
// Backpressure: none here; the caller must not write more than DEPTH - o_count halfwords.
// Ports: i_clr empties the buffer; i_wr_en/i_wr_data/i_wr_off write halfwords
//        i_wr_off..HPB-1 at the tail; i_rd_en/i_rd_cnt pop up to 4 halfwords from the head.
module hw_ring_buffer #(
    parameter int DEPTH = 16,
    parameter int HPB   = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int OW   = $clog2(HPB)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_wr_en,
    input  logic [HPB*16-1:0] i_wr_data,
    input  logic [OW-1:0]     i_wr_off,
    input  logic              i_rd_en,
    input  logic [2:0]        i_rd_cnt,
    output logic [PW:0]       o_count,
    output logic [63:0]       o_peek
);

    logic [15:0]   r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic [PW:0]   w_wr_cnt;
    logic [PW:0]   w_rd_cnt;

    assign w_wr_cnt = i_wr_en ? ((PW+1)'(HPB) - (PW+1)'(i_wr_off)) : '0;
    assign w_rd_cnt = i_rd_en ? (PW+1)'(i_rd_cnt) : '0;
    assign o_count  = r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_rd_cnt);
            r_tail  <= r_tail + PW'(w_wr_cnt);
            r_count <= r_count + w_wr_cnt - w_rd_cnt;
        end
    end

    // Halfwords below the offset belong to bytes before the fetch target and are dropped,
    // so halfword i lands at tail + (i - off).
    always_ff @(posedge clk) begin
        if (i_wr_en && !i_clr && !rst) begin
            for (int i = 0; i < HPB; i++) begin
                if (OW'(i) >= i_wr_off) begin
                    r_mem[r_tail + PW'(i) - PW'(i_wr_off)] <= i_wr_data[16*i +: 16];
                end
            end
        end
    end

    always_comb begin
        o_peek = '0;
        for (int j = 0; j < 4; j++) begin
            o_peek[16*j +: 16] = r_mem[r_head + PW'(j)];
        end
    end

endmodule

// File: rtl/fetch_align_buffer.sv
// Fetch queue splitting I-cache blocks into RVC/RV32 instructions for decode.
// Latency: a block accepted at edge t can be emitted from cycle t+1; up to DEC_WIDTH per cycle.
// Backpressure: fetch_ready only when a whole block fits (registered count, no dequeue credit);
//               out_ready accepts all valid slots at once; flush overrides both.
// Ports: fetch_* block input, flush/flush_order redirect, out_* packed slots toward decode.
module fetch_align_buffer
    import rv32i_types::*;
#(
    parameter int          FETCH_WIDTH = 64,
    parameter int          DEPTH       = 16,
    parameter int          DEC_WIDTH   = 2,
    parameter logic [31:0] RESET_PC    = 32'h1eceb000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_valid,
    output logic                    fetch_ready,
    input  logic [FETCH_WIDTH-1:0]  fetch_data,
    input  logic [31:0]             fetch_pc,
    input  logic                    flush,
    input  logic [63:0]             flush_order,
    output logic [DEC_WIDTH-1:0]    out_valid,
    input  logic                    out_ready,
    output logic [DEC_WIDTH*32-1:0] out_inst,
    output logic [DEC_WIDTH*32-1:0] out_pc,
    output logic [DEC_WIDTH*64-1:0] out_order,
    output logic [DEC_WIDTH-1:0]    out_is_compressed
);

    localparam int HPB = FETCH_WIDTH / 16;
    localparam int PW  = $clog2(DEPTH);
    localparam int BW  = $clog2(FETCH_WIDTH / 8);

    logic [31:0]  r_head_pc;
    logic [63:0]  r_order;
    logic [PW:0]  w_count;
    logic [63:0]  w_peek;
    logic         w_enq;
    logic         w_deq;
    logic [15:0]  w_h0;
    logic [15:0]  w_h1;
    logic [15:0]  w_h1_hi;
    logic         w_c0;
    logic         w_c1;
    logic [2:0]   w_len0;
    logic [2:0]   w_len1;
    logic         w_v0;
    logic         w_v1;
    logic [2:0]   w_rd_cnt;
    align_slot_t  w_slot [2];

    assign fetch_ready = w_count <= (PW+1)'(DEPTH - HPB);
    assign w_enq       = fetch_valid && fetch_ready && !flush;

    hw_ring_buffer #(.DEPTH(DEPTH), .HPB(HPB)) u_ring (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (flush),
        .i_wr_en   (w_enq),
        .i_wr_data (fetch_data),
        .i_wr_off  (fetch_pc[BW-1:1]),
        .i_rd_en   (w_deq),
        .i_rd_cnt  (w_rd_cnt),
        .o_count   (w_count),
        .o_peek    (w_peek)
    );

    // Slot 1 starts right after slot 0, so its halfwords depend on len0.
    assign w_h0    = w_peek[15:0];
    assign w_c0    = rvc_is_compressed(w_h0);
    assign w_len0  = w_c0 ? 3'd1 : 3'd2;
    assign w_h1    = w_c0 ? w_peek[31:16] : w_peek[47:32];
    assign w_h1_hi = w_c0 ? w_peek[47:32] : w_peek[63:48];
    assign w_c1    = rvc_is_compressed(w_h1);
    assign w_len1  = w_c1 ? 3'd1 : 3'd2;

    // A straddling RV32 whose upper half has not arrived yet leaves the slot invalid.
    assign w_v0 = w_count >= (PW+1)'(w_len0);
    assign w_v1 = (DEC_WIDTH == 2) && w_v0 && (w_count >= (PW+1)'(w_len0 + w_len1));

    assign w_deq    = out_ready && w_v0 && !flush;
    assign w_rd_cnt = w_len0 + (w_v1 ? w_len1 : 3'd0);

    always_comb begin
        w_slot[0].inst          = w_c0 ? {16'h0000, w_h0} : {w_peek[31:16], w_h0};
        w_slot[0].pc            = r_head_pc;
        w_slot[0].order         = r_order;
        w_slot[0].is_compressed = w_c0;
        w_slot[0].valid         = w_v0;
        w_slot[1].inst          = w_c1 ? {16'h0000, w_h1} : {w_h1_hi, w_h1};
        w_slot[1].pc            = r_head_pc + 32'({w_len0, 1'b0});
        w_slot[1].order         = r_order + 64'd1;
        w_slot[1].is_compressed = w_c1;
        w_slot[1].valid         = w_v1;
    end

    for (genvar k = 0; k < DEC_WIDTH; k++) begin : g_pack
        assign out_valid[k]          = w_slot[k].valid;
        assign out_inst[32*k +: 32]  = w_slot[k].inst;
        assign out_pc[32*k +: 32]    = w_slot[k].pc;
        assign out_order[64*k +: 64] = w_slot[k].order;
        assign out_is_compressed[k]  = w_slot[k].is_compressed;
    end

    // head_pc is left alone on flush: the next block arrives into an empty buffer and reloads it.
    // An empty buffer cannot dequeue, so reload and advance never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_pc <= RESET_PC;
            r_order   <= '0;
        end else if (flush) begin
            r_order   <= flush_order;
        end else begin
            if (w_enq && (w_count == '0)) begin
                r_head_pc <= fetch_pc;
            end else if (w_deq) begin
                r_head_pc <= r_head_pc + 32'({w_rd_cnt, 1'b0});
            end
            if (w_deq) begin
                r_order <= r_order + (w_v1 ? 64'd2 : 64'd1);
            end
        end
    end

    a_count_le_depth: assert property (@(posedge clk) disable iff (rst) w_count <= (PW+1)'(DEPTH));
    a_enq_only_ready: assert property (@(posedge clk) disable iff (rst) w_enq |-> fetch_ready);
    a_valid_thermo:   assert property (@(posedge clk) disable iff (rst)
                                       out_valid[DEC_WIDTH-1] |-> out_valid[0]);

endmodule

// File: tb/tb_fetch_align_buffer.sv
module tb_fetch_align_buffer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         fetch_valid = 1'b0;
    logic         fetch_ready;
    logic [63:0]  fetch_data = '0;
    logic [31:0]  fetch_pc = '0;
    logic         flush = 1'b0;
    logic [63:0]  flush_order = '0;
    logic [1:0]   out_valid;
    logic         out_ready = 1'b0;
    logic [63:0]  out_inst;
    logic [63:0]  out_pc;
    logic [127:0] out_order;
    logic [1:0]   out_is_compressed;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [63:0] order;
        logic        comp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fetch_align_buffer dut (
        .clk               (clk),
        .rst               (rst),
        .fetch_valid       (fetch_valid),
        .fetch_ready       (fetch_ready),
        .fetch_data        (fetch_data),
        .fetch_pc          (fetch_pc),
        .flush             (flush),
        .flush_order       (flush_order),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_inst          (out_inst),
        .out_pc            (out_pc),
        .out_order         (out_order),
        .out_is_compressed (out_is_compressed)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] inst, input logic [31:0] pc,
                            input logic [63:0] order, input logic comp);
        exp_t e;
        e.inst = inst; e.pc = pc; e.order = order; e.comp = comp;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that took the block.
    task automatic enq(input logic [31:0] pc, input logic [63:0] d);
        int n;
        n = 0;
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        fetch_data  = d;
        @(negedge clk);
        while (!fetch_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!fetch_ready) chk("enq_timeout", 64'(fetch_ready), 64'd1);
        step();
        fetch_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            n++;
            step();
        end
        step();
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [63:0] rvc_blk(input int base);
        logic [63:0] d;
        for (int j = 0; j < 4; j++) d[16*j +: 16] = {12'(base + j), 4'h1};
        return d;
    endfunction

    // Scoreboard: every slot transferred (ready & valid, no flush) is popped and compared.
    always @(negedge clk) begin
        if (!rst && out_ready && out_valid[0] && !flush) begin
            for (int k = 0; k < 2; k++) begin
                if (out_valid[k]) begin
                    if (sb.size() == 0) begin
                        chk("sb_extra", 64'(sb.size()), 64'd1);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk($sformatf("inst%0d", k), 64'(out_inst[32*k +: 32]), 64'(e.inst));
                        chk($sformatf("pc%0d", k), 64'(out_pc[32*k +: 32]), 64'(e.pc));
                        chk($sformatf("order%0d", k), out_order[64*k +: 64], e.order);
                        chk($sformatf("comp%0d", k), 64'(out_is_compressed[k]), 64'(e.comp));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);
        step();

        // Mixed RVC/RVC/RV32 block
        out_ready = 1'b0;
        enq(32'h1eceb000, 64'h00a00093_4501_0505);
        push_exp(32'h00000505, 32'h1eceb000, 64'd0, 1'b1);
        push_exp(32'h00004501, 32'h1eceb002, 64'd1, 1'b1);
        push_exp(32'h00a00093, 32'h1eceb004, 64'd2, 1'b0);
        @(negedge clk);
        chk("t2_valid", 64'(out_valid), 64'd3);
        chk("t2_pc0", 64'(out_pc[31:0]), 64'h1eceb000);
        chk("t2_order0", out_order[63:0], 64'd0);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("t2_valid_one", 64'(out_valid), 64'd1);
        step();
        @(negedge clk);
        chk("t2_valid_empty", 64'(out_valid), 64'd0);
        step();
        chk("t2_sb", 64'(sb.size()), 64'd0);

        // Straddling RV32 across two blocks
        enq(32'h1eceb000, 64'h0093_4501_4501_4501);
        push_exp(32'h00004501, 32'h1eceb000, 64'd3, 1'b1);
        push_exp(32'h00004501, 32'h1eceb002, 64'd4, 1'b1);
        push_exp(32'h00004501, 32'h1eceb004, 64'd5, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t3_straddle_hold", 64'(out_valid), 64'd0);
        step();
        enq(32'h1eceb008, 64'h0001_0001_0001_00a0);
        push_exp(32'h00a00093, 32'h1eceb006, 64'd6, 1'b0);
        push_exp(32'h00000001, 32'h1eceb00a, 64'd7, 1'b1);
        push_exp(32'h00000001, 32'h1eceb00c, 64'd8, 1'b1);
        push_exp(32'h00000001, 32'h1eceb00e, 64'd9, 1'b1);
        drain("t3_drain");

        // Redirect to a halfword inside a block
        flush = 1'b1;
        flush_order = 64'd100;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("t4_flush_valid", 64'(out_valid), 64'd0);
        step();
        enq(32'h1eceb00a, 64'h0001_0002_4501_dead);
        push_exp(32'h00004501, 32'h1eceb00a, 64'd100, 1'b1);
        push_exp(32'h00000002, 32'h1eceb00c, 64'd101, 1'b1);
        push_exp(32'h00000001, 32'h1eceb00e, 64'd102, 1'b1);
        drain("t4_drain");

        // Back-pressure: fill to DEPTH, then release halfwords around the threshold
        out_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            enq(32'h1eceb020 + 32'(8 * b), rvc_blk(4 * b));
            for (int j = 0; j < 4; j++)
                push_exp(32'({12'(4 * b + j), 4'h1}), 32'h1eceb020 + 32'(8 * b + 2 * j),
                         64'(103 + 4 * b + j), 1'b1);
        end
        @(negedge clk);
        chk("t5_full_ready", 64'(fetch_ready), 64'd0);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("t5_14_ready", 64'(fetch_ready), 64'd0);
        step();
        out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("t5_8_ready", 64'(fetch_ready), 64'd1);
        chk("t5_sb_left", 64'(sb.size()), 64'd8);
        step();
        out_ready = 1'b1;
        drain("t5_drain");

        // Flush, fetch and accept in the same cycle with five halfwords held
        out_ready = 1'b0;
        enq(32'h1eceb046, 64'h0001_dead_beef_cafe);
        enq(32'h1eceb048, rvc_blk(64));
        @(negedge clk);
        chk("t6_pre_valid", 64'(out_valid), 64'd3);
        step();
        flush = 1'b1;
        flush_order = 64'd500;
        fetch_valid = 1'b1;
        fetch_pc = 32'h1eceb050;
        fetch_data = 64'h7771_7771_7771_7771;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        fetch_valid = 1'b0;
        @(negedge clk);
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_ready", 64'(fetch_ready), 64'd1);
        step();
        enq(32'h1eceb100, rvc_blk(32));
        for (int j = 0; j < 4; j++)
            push_exp(32'({12'(32 + j), 4'h1}), 32'h1eceb100 + 32'(2 * j), 64'(500 + j), 1'b1);
        drain("t6_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_align_buffer.md
Name: fetch_align_buffer

Overview:
- Parametrised halfword-granular fetch queue between the I-cache fetch stage and decode.
- Accepts fetch blocks of FETCH_WIDTH bits and splits them into RVC (16-bit) and RV32 (32-bit) instructions.
- Handles 32-bit instructions that straddle fetch blocks and halfword-aligned redirect targets.
- Emits up to DEC_WIDTH instructions per cycle, each with pc, order and compressed flag, for decode_compressed and the main decoder.

Parameters:
- FETCH_WIDTH, 64: fetch block width in bits; legal values 32, 64, 128. HPB = FETCH_WIDTH/16 halfwords per block.
- DEPTH, 16: buffer capacity in halfwords; power of 2; must be >= 2*HPB.
- DEC_WIDTH, 2: output slots per cycle; legal values 1, 2.
- RESET_PC, 32'h1eceb000: head pc after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- fetch_valid  in  1  fetch block present
- fetch_ready  out  1  buffer can accept a whole block
- fetch_data  in  FETCH_WIDTH  block; halfword i is bits [16i+15:16i] (little-endian)
- fetch_pc  in  32  byte pc of first useful halfword; bit0 = 0; block start = fetch_pc aligned down to FETCH_WIDTH/8 bytes
- flush  in  1  redirect/flush; kills buffer contents
- flush_order  in  64  order value of the next instruction after flush
- out_valid  out  DEC_WIDTH  per-slot valid; thermometer-coded, slot k valid only if slot k-1 valid
- out_ready  in  1  consumer accepts all valid slots this cycle
- out_inst  out  DEC_WIDTH*32  instruction; RVC zero-extended in [31:16]
- out_pc  out  DEC_WIDTH*32  instruction pc
- out_order  out  DEC_WIDTH*64  sequential instruction order
- out_is_compressed  out  DEC_WIDTH  1 when inst[1:0] != 2'b11

Behaviour:
Reset (rst high at a clk edge):
- count = 0, head/tail pointers = 0, head_pc = RESET_PC, order = 0.
- Resulting outputs: out_valid = 0, fetch_ready = 1.

Enqueue:
- fetch_ready = (DEPTH - count) >= HPB, computed from the registered count only; same-cycle dequeues are not credited.
- Block is accepted when fetch_valid & fetch_ready & !flush.
- off = fetch_pc[$clog2(FETCH_WIDTH/8)-1:1]. Halfwords off..HPB-1 are written at tail; halfwords below off are dropped; count increases by HPB-off.
- When count == 0 at enqueue, head_pc <= fetch_pc. Otherwise fetch is required to deliver sequential blocks and head_pc is not reloaded.

Output decode (combinational from registered state; data enqueued at edge t is visible from cycle t+1):
- Slot 0 examines the head halfword h0.
  - h0[1:0] != 11: RVC, length 1; needs count >= 1.
  - Otherwise RV32, length 2; needs count >= 2.
  - If insufficient halfwords (straddle), slot 0 is invalid.
- Slot 1 (DEC_WIDTH=2) starts at head + len0 and applies the same rule with count - len0.
- out_pc: slot0 = head_pc, slot1 = head_pc + 2*len0.
- out_order: slot0 = order, slot1 = order + 1.
- 48-bit and longer encodings are unsupported and are treated as RV32.

Dequeue (out_ready & out_valid[0]):
- head advances by the sum of valid slot lengths; count decreases by the same.
- head_pc increases by 2*sum; order increases by the number of valid slots.

Simultaneous events:
- Enqueue and dequeue in the same cycle: count_next = count + in - out. Pointers wrap modulo DEPTH.
- flush has priority over everything:
  - count, head and tail go to 0; order <= flush_order.
  - Same-cycle fetch beat and dequeue are ignored; out_valid = 0 the following cycle.
  - head_pc reloads from the first post-flush block.
- rst mid-operation: same as reset; any partially held straddle halfword is discarded.

Invariants (checked by assertions):
- count <= DEPTH.
- No enqueue occurs when fetch_ready = 0.
- out_valid is thermometer-coded.

Decomposition:
- rv32i_types holds:
  - typedef align_slot_t {inst[31:0], pc[31:0], order[63:0], is_compressed, valid}.
  - The function rvc_is_compressed(halfword).
- The top-level packs slots into the flat output ports.
- Sub-module hw_ring_buffer (parameters DEPTH, HPB) owns storage, pointers, count and multi-halfword write/read.
- fetch_align_buffer holds the length detection, pc/order tracking and flush logic.

Test Plan (FETCH_WIDTH=64, DEPTH=16, DEC_WIDTH=2):
1. Reset -> out_valid=00, fetch_ready=1. After one enqueue, slot 0 pc=0x1eceb000 and order=0.
2. fetch_pc=0x1eceb000, data=64'h00a00093_4501_0505 -> next cycle:
   - slot0: inst 0x00000505, pc 0x1eceb000, comp=1, order 0.
   - slot1: inst 0x00004501, pc 0x1eceb002, order 1.
   - After accept: slot0 inst 0x00a00093, pc 0x1eceb004, comp=0, order 2; slot1 invalid.
3. Straddle: block A=64'h0093_4501_4501_4501 at 0x1eceb000 -> three RVC emitted, then out_valid=00. Block B with hw0=0x00a0 at 0x1eceb008 -> slot0 inst 0x00a00093, pc 0x1eceb006.
4. Redirect: flush with flush_order=100, then block at fetch_pc=0x1eceb00a (off=1) -> hw0 dropped, count=3, first slot pc 0x1eceb00a, order 100.
5. Back-pressure: out_ready=0, four blocks pushed -> count=16, fetch_ready=0. One accept of two RVC -> count=14, fetch_ready still 0. Accept six more halfwords -> count=8, fetch_ready=1.
6. flush, fetch_valid and out_ready all high in the same cycle with count=5 -> next cycle count=0, out_valid=00, fetch beat not stored, order=flush_order.
